// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide single-port memory between the
// instruction-fetch (IF) and load/store (DM) requesters. Each word access
// is four big-endian byte beats. The addressed byte carries bits 31:24.
// Round-robin arbitration applies when both requesters ask in the same cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [31:0]           dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic [31:0]           dm_rdata,
  output logic                  dm_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t                state;
  logic [1:0]            beat;
  logic                  last_grant;
  logic                  grant_q;
  logic                  we_q;
  logic [31:0]           wshift;
  logic [23:0]           assembly;

  logic                  pick;
  logic                  any_req;
  logic [31:0]           addr_sel;
  logic [ADDR_WIDTH-1:0] base_next;
  logic                  we_next;

  // The address bits that the memory cannot reach are dropped on purpose,
  // so addresses alias modulo the memory size. The low two bits are also dropped
  // because accesses are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH], if_addr[1:0],
                              dm_addr[31:ADDR_WIDTH], dm_addr[1:0]};

  // This logic chooses the requester to serve. When both ask, the one not
  // served last wins.
  always_comb begin
    pick = GRANT_IF;
    if (if_req && dm_req) pick = ~last_grant;
    else if (dm_req)      pick = GRANT_DM;
    any_req   = if_req | dm_req;
    addr_sel  = (pick == GRANT_DM) ? dm_addr : if_addr;
    base_next = {addr_sel[ADDR_WIDTH-1:2], 2'b00};
    we_next   = (pick == GRANT_DM) ? dm_we : 1'b0;
  end

  // The write strobe is combinational so that an asynchronous reset removes it at once.
  assign mem_we = (state == XFER) && we_q;

  // This block is the access sequencer. It latches the grant, steps through the four
  // byte beats, and then raises a one-cycle ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      last_grant <= GRANT_DM;
      grant_q    <= GRANT_IF;
      we_q       <= 1'b0;
      wshift     <= 32'h0;
      assembly   <= 24'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= XFER;
            beat       <= 2'd0;
            grant_q    <= pick;
            last_grant <= pick;
            we_q       <= we_next;
            mem_addr   <= base_next;
            mem_wdata  <= we_next ? dm_wdata[31:24] : 8'h0;
            wshift     <= we_next ? {dm_wdata[23:0], 8'h0} : 32'h0;
            busy       <= 1'b1;
          end
        end
        XFER: begin
          if (!we_q) assembly <= {assembly[15:0], mem_rdata};
          if (beat == 2'd3) begin
            state     <= DONE;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
            if (grant_q == GRANT_DM) begin
              dm_ready <= 1'b1;
              if (!we_q) dm_rdata <= {assembly, mem_rdata};
            end else begin
              if_ready <= 1'b1;
              if_rdata <= {assembly, mem_rdata};
            end
          end else begin
            beat      <= beat + 2'd1;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= wshift[31:24];
            wshift    <= {wshift[23:0], 8'h0};
          end
        end
        DONE: begin
          state    <= IDLE;
          beat     <= 2'd0;
          if_ready <= 1'b0;
          dm_ready <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed testbench for mem_port_arbiter. It includes a
// byte-memory model and checks against hand-computed expected values.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // This block generates the free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The memory model has a combinational read and writes on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // applyStimulus drives one uncontended access. It checks the address and
  // write strobe on every beat, then the ready pulse and the return to idle.
  task automatic applyStimulus(input bit use_dm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [9:0] exp_base,
                               output logic [31:0] rdata);
    logic [31:0] wd;
    @(negedge clk);
    if (use_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wd = wdata;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("beat_addr", {22'h0, mem_addr}, {22'h0, exp_base + 10'(k)});
      checkOutput("beat_we", {31'h0, mem_we}, {31'h0, we});
      if (we) checkOutput("beat_wdata", {24'h0, mem_wdata}, {24'h0, wd[31:24]});
      wd = wd << 8;
    end
    @(negedge clk);
    checkOutput("if_ready", {31'h0, if_ready}, {31'h0, !use_dm});
    checkOutput("dm_ready", {31'h0, dm_ready}, {31'h0, use_dm});
    checkOutput("done_we", {31'h0, mem_we}, 32'h0);
    checkOutput("done_busy", {31'h0, busy}, 32'h1);
    rdata = use_dm ? dm_rdata : if_rdata;
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    checkOutput("ready_pulse", {30'h0, if_ready, dm_ready}, 32'h0);
    checkOutput("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        seq [0:2];
  int          n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h10; mem[3] = 8'h22;
    mem[10'h3FC] = 8'hA1; mem[10'h3FD] = 8'hB2; mem[10'h3FE] = 8'hC3; mem[10'h3FF] = 8'hD4;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    checkOutput("rst_flags", {28'h0, mem_we, busy, if_ready, dm_ready}, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 10'h000, rd);
    checkOutput("if_read", rd, 32'h00011022);

    applyStimulus(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 10'h020, rd);
    checkOutput("wr_keeps_rdata", dm_rdata, 32'h0);
    checkOutput("mem_20_23", {mem[10'h20], mem[10'h21], mem[10'h22], mem[10'h23]}, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b0, 32'h22, 32'h0, 10'h020, rd);
    checkOutput("dm_read_unaligned", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 10'h000, rd);
    checkOutput("wrap_400", rd, 32'h00011022);
    applyStimulus(1'b1, 1'b0, 32'h3FF, 32'h0, 10'h3FC, rd);
    checkOutput("wrap_3ff", rd, 32'hA1B2C3D4);

    // Arbitration test: both requesters are held high from reset.
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3FC;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      checkOutput("one_ready", {31'h0, if_ready & dm_ready}, 32'h0);
      if (if_ready || dm_ready) begin
        seq[n] = dm_ready;
        n++;
        if (n == 3) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
    end
    checkOutput("arb_count", n, 3);
    if (n == 3) begin
      checkOutput("arb_first_if", {31'h0, seq[0]}, 32'h0);
      checkOutput("arb_second_dm", {31'h0, seq[1]}, 32'h1);
      checkOutput("arb_third_if", {31'h0, seq[2]}, 32'h0);
    end
    checkOutput("arb_if_rdata", if_rdata, 32'h00011022);
    checkOutput("arb_dm_rdata", dm_rdata, 32'hA1B2C3D4);

    // Reset arrives in the middle of a write, during beat 2.
    @(negedge clk);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h11223344;
    repeat (3) @(negedge clk);
    checkOutput("mid_we_before", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_we_drop", {31'h0, mem_we}, 32'h0);
    checkOutput("mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("mid_readies", {30'h0, if_ready, dm_ready}, 32'h0);
    checkOutput("mid_if_rdata", if_rdata, 32'h0);
    checkOutput("mid_dm_rdata", dm_rdata, 32'h0);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("mid_no_ready", {31'h0, dm_ready}, 32'h0);
    end
    checkOutput("mid_mem_40_43", {mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]},
                32'h11220000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 10'h000, rd);
    checkOutput("if_after_reset", rd, 32'h00011022);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
